alu_mc: RTL and testbench

Parametrised, registered, multi-cycle successor to the 16-bit combinational ALU of the ERM16 datapath.
- Accepts one operation per start/ready handshake and returns a registered result with a one-cycle done pulse.
- Holds result and flags stable between operations.
- Replaces the combinational divide/modulo with an iterative divider, so the core no longer carries a WIDTH-bit combinational divide path.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_div.sv | 69 ++++++
 rtl/alu_mc.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_mc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode enum and flag layout for the multi-cycle ALU.
// Opcodes 18/19 only decode when ALU_SIGNED_DIV_EN is defined.
package alu_pkg;

  localparam int FLAGS_W = 6;

  localparam int FLAG_ZF = 5;
  localparam int FLAG_CF = 4;
  localparam int FLAG_SF = 3;
  localparam int FLAG_PF = 2;
  localparam int FLAG_GF = 1;
  localparam int FLAG_LF = 0;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_MOD  = 5'd4,
    OP_MVN  = 5'd5,
    OP_OR   = 5'd6,
    OP_AND  = 5'd7,
    OP_NOR  = 5'd8,
    OP_NAND = 5'd9,
    OP_XOR  = 5'd10,
    OP_XNOR = 5'd11,
    OP_REV  = 5'd12,
    OP_LSL  = 5'd13,
    OP_LSR  = 5'd14,
    OP_ASR  = 5'd15,
    OP_NOP  = 5'd16,
    OP_CMP  = 5'd17,
    OP_SDIV = 5'd18,
    OP_SMOD = 5'd19
  } alu_op_e;

endpackage

// File: rtl/alu_div.sv
// Radix-2 restoring divider: loads on start, then one quotient bit per cycle
// for WIDTH cycles; valid pulses once when quotient/remainder are final.
module alu_div
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             valid,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dsr;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while quotient bits enter at the LSB.
  assign shifted = {remainder, quotient[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr};
  assign last    = busy && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient  <= '0;
      remainder <= '0;
      dsr       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      dbz       <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        quotient  <= dividend;
        remainder <= '0;
        dsr       <= divisor;
        dbz       <= (divisor == '0);
        cnt       <= '0;
        busy      <= 1'b1;
      end else if (busy) begin
        if (trial[WIDTH]) begin
          remainder <= shifted[WIDTH-1:0];
          quotient  <= {quotient[WIDTH-2:0], 1'b0};
        end else begin
          remainder <= trial[WIDTH-1:0];
          quotient  <= {quotient[WIDTH-2:0], 1'b1};
        end
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: single-cycle ops complete one edge after accept,
// DIV/MOD run through alu_div. Define ALU_SIGNED_DIV_EN to add SDIV/SMOD.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FUNC_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [FUNC_W-1:0]  func,
  input  logic [FLAGS_W-1:0] flags_in,
  output logic [WIDTH-1:0]   y,
  output logic [FLAGS_W-1:0] flags_out,
  output logic               done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int NBYTES = WIDTH / 8;

  // Handshake: a request is accepted on a rising edge where start=1 and
  // ready=1; start while ready=0 is dropped. done pulses for exactly one
  // cycle per accepted request, with y/flags_out updated in that cycle.
  logic [1:0]        state;
  logic              accept;
  logic              start_div;
  logic              alu_pend;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [FUNC_W-1:0] op_func;
  logic              op_cin;
  logic              unused_flags;

  logic [WIDTH-1:0]  div_dividend;
  logic [WIDTH-1:0]  div_divisor;
  logic [WIDTH-1:0]  div_quo;
  logic [WIDTH-1:0]  div_rem;
  logic              div_dbz;
  logic              div_valid;
  logic              div_last;
  logic              div_mod;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       lsl_ext;
  logic [WIDTH:0]       lsr_ext;
  logic signed [WIDTH:0] asr_ext;
  logic [WIDTH-1:0]     cmp_diff;
  logic [WIDTH-1:0]     rev;

  logic [WIDTH-1:0]   alu_y;
  logic [FLAGS_W-1:0] alu_f;
  logic               alu_std;
  logic               alu_keep;
  logic [WIDTH-1:0]   div_y;
  logic [FLAGS_W-1:0] div_f;

  function automatic logic is_div(input logic [FUNC_W-1:0] f);
    is_div = (f == FUNC_W'(OP_DIV)) || (f == FUNC_W'(OP_MOD))
`ifdef ALU_SIGNED_DIV_EN
          || (f == FUNC_W'(OP_SDIV)) || (f == FUNC_W'(OP_SMOD))
`endif
          ;
  endfunction

  assign ready        = (state == S_IDLE);
  assign accept       = start && ready;
  assign start_div    = accept && is_div(func);
  assign unused_flags = ^{flags_in[5:4], flags_in[2:0]};

`ifdef ALU_SIGNED_DIV_EN
  logic signed_in;
  logic [WIDTH-1:0] min_neg;
  assign signed_in    = (func == FUNC_W'(OP_SDIV)) || (func == FUNC_W'(OP_SMOD));
  assign min_neg      = {1'b1, {(WIDTH-1){1'b0}}};
  assign div_dividend = (signed_in && a[WIDTH-1]) ? -a : a;
  assign div_divisor  = (signed_in && b[WIDTH-1]) ? -b : b;
  assign div_mod      = (op_func == FUNC_W'(OP_MOD)) || (op_func == FUNC_W'(OP_SMOD));
`else
  assign div_dividend = a;
  assign div_divisor  = b;
  assign div_mod      = (op_func == FUNC_W'(OP_MOD));
`endif

  alu_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_div),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem),
    .dbz       (div_dbz),
    .valid     (div_valid),
    .last      (div_last)
  );

  assign sum      = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
  assign diff     = {1'b0, op_a} - {1'b0, op_b} - {{WIDTH{1'b0}}, op_cin};
  assign prod     = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
  assign cmp_diff = op_a - op_b;
  // One guard bit on the shifted-out side captures SF for every amount,
  // including amount >= WIDTH, without a separate bit-select mux.
  assign lsl_ext  = {1'b0, op_a} << op_b;
  assign lsr_ext  = {op_a, 1'b0} >> op_b;
  assign asr_ext  = $signed({op_a, 1'b0}) >>> op_b;

  always_comb begin
    rev = op_b;
    for (int i = 0; i < NBYTES; i++) begin
      rev[i*8 +: 8] = op_b[(NBYTES-1-i)*8 +: 8];
    end
  end

  always_comb begin
    alu_y    = '0;
    alu_f    = '0;
    alu_std  = 1'b1;
    alu_keep = 1'b0;
    case (op_func)
      FUNC_W'(OP_ADD):  begin alu_y = sum[WIDTH-1:0];  alu_f[FLAG_CF] = sum[WIDTH];  end
      FUNC_W'(OP_SUB):  begin alu_y = diff[WIDTH-1:0]; alu_f[FLAG_CF] = diff[WIDTH]; end
      FUNC_W'(OP_MUL):  begin
        alu_y          = prod[WIDTH-1:0];
        alu_f[FLAG_CF] = |prod[2*WIDTH-1:WIDTH];
      end
      FUNC_W'(OP_MVN):  alu_y = ~op_b;
      FUNC_W'(OP_OR):   alu_y = op_a | op_b;
      FUNC_W'(OP_AND):  alu_y = op_a & op_b;
      FUNC_W'(OP_NOR):  alu_y = ~(op_a | op_b);
      FUNC_W'(OP_NAND): alu_y = ~(op_a & op_b);
      FUNC_W'(OP_XOR):  alu_y = op_a ^ op_b;
      FUNC_W'(OP_XNOR): alu_y = ~(op_a ^ op_b);
      FUNC_W'(OP_REV):  alu_y = rev;
      FUNC_W'(OP_LSL):  begin alu_y = lsl_ext[WIDTH-1:0]; alu_f[FLAG_SF] = lsl_ext[WIDTH]; end
      FUNC_W'(OP_LSR):  begin alu_y = lsr_ext[WIDTH:1];   alu_f[FLAG_SF] = lsr_ext[0];     end
      FUNC_W'(OP_ASR):  begin alu_y = asr_ext[WIDTH:1];   alu_f[FLAG_SF] = asr_ext[0];     end
      FUNC_W'(OP_NOP):  begin alu_keep = 1'b1; alu_std = 1'b0; end
      FUNC_W'(OP_CMP):  begin
        alu_std        = 1'b0;
        alu_f[FLAG_ZF] = (op_a == op_b);
        alu_f[FLAG_GF] = (op_a > op_b);
        alu_f[FLAG_LF] = (op_a < op_b);
        alu_f[FLAG_PF] = ~^cmp_diff;
      end
      default: alu_std = 1'b0;
    endcase
    if (alu_std) begin
      alu_f[FLAG_ZF] = (alu_y == '0);
      alu_f[FLAG_PF] = ~^alu_y;
    end
  end

  always_comb begin
    div_y = div_mod ? div_rem : div_quo;
    div_f = '0;
    if (div_dbz) begin
      div_y          = div_mod ? op_a : '1;
      div_f[FLAG_CF] = 1'b1;
    end
`ifdef ALU_SIGNED_DIV_EN
    else if (op_func == FUNC_W'(OP_SDIV)) begin
      div_y          = (op_a[WIDTH-1] ^ op_b[WIDTH-1]) ? -div_quo : div_quo;
      div_f[FLAG_CF] = (op_a == min_neg) && (op_b == '1);
    end else if (op_func == FUNC_W'(OP_SMOD)) begin
      div_y = op_a[WIDTH-1] ? -div_rem : div_rem;
    end
`endif
    div_f[FLAG_ZF] = (div_y == '0);
    div_f[FLAG_PF] = ~^div_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      alu_pend  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_func   <= '0;
      op_cin    <= 1'b0;
      y         <= '0;
      flags_out <= '0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      alu_pend <= accept && !is_div(func);
      if (accept) begin
        op_a    <= a;
        op_b    <= b;
        op_func <= func;
        op_cin  <= flags_in[FLAG_SF];
      end
      if (alu_pend) begin
        if (!alu_keep) begin
          y         <= alu_y;
          flags_out <= alu_f;
        end
        done <= 1'b1;
      end
      case (state)
        S_IDLE:   if (start_div) state <= S_DIVIDE;
        S_DIVIDE: if (div_last) state <= S_DONE;
        S_DONE: begin
          if (div_valid) begin
            y         <= div_y;
            flags_out <= div_f;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed corner cases plus random traffic, all checked
// against an arithmetic model with a due-cycle expectation queue.
module tb_alu_mc;

  localparam int W = 16;
  localparam int DIV_LAT = W + 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   func;
  logic [5:0]   flags_in;
  logic [W-1:0] y;
  logic [5:0]   flags_out;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  int ecount   = 0;
  int busy_end = 0;
  logic [W-1:0] exp_q[$];
  logic [5:0]   exp_flags_q[$];
  int           exp_due_q[$];
  logic [21:0]  m_prev = '0;
  logic [21:0]  m_res;
  logic         m_acc;

  alu_mc #(.WIDTH(W), .FUNC_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
    .a         (a),
    .b         (b),
    .func      (func),
    .flags_in  (flags_in),
    .y         (y),
    .flags_out (flags_out),
    .done      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit is_div_op(input logic [4:0] f);
`ifdef ALU_SIGNED_DIV_EN
    return (f == 5'd3) || (f == 5'd4) || (f == 5'd18) || (f == 5'd19);
`else
    return (f == 5'd3) || (f == 5'd4);
`endif
  endfunction

  // Reference behaviour, straight from the opcode table; returns {y, flags}.
  function automatic logic [21:0] model(input logic [4:0] f, input logic [W-1:0] x,
                                        input logic [W-1:0] z, input logic c,
                                        input logic [21:0] prev);
    longint ua, ub, r;
    int sa, sz;
    logic [W-1:0] ry;
    logic [5:0] fl;
    bit std;
    ua = longint'(x);
    ub = longint'(z);
    sa = int'($signed(x));
    sz = int'($signed(z));
    ry = '0;
    fl = '0;
    std = 1'b1;
    case (f)
      5'd0: begin r = ua + ub + longint'(c); ry = 16'(r); fl[4] = (r > 65535); end
      5'd1: begin r = ua - ub - longint'(c); ry = 16'(r); fl[4] = (r < 0); end
      5'd2: begin r = ua * ub; ry = 16'(r); fl[4] = ((r >> 16) != 0); end
      5'd3: begin
        if (ub == 0) begin ry = 16'hFFFF; fl[4] = 1'b1; end
        else ry = 16'(ua / ub);
      end
      5'd4: begin
        if (ub == 0) begin ry = x; fl[4] = 1'b1; end
        else ry = 16'(ua % ub);
      end
      5'd5:  ry = ~z;
      5'd6:  ry = x | z;
      5'd7:  ry = x & z;
      5'd8:  ry = ~(x | z);
      5'd9:  ry = ~(x & z);
      5'd10: ry = x ^ z;
      5'd11: ry = ~(x ^ z);
      5'd12: ry = {z[7:0], z[15:8]};
      5'd13: begin
        ry = (ub >= 16) ? 16'h0 : 16'(ua << ub);
        fl[3] = (ub >= 1 && ub <= 16) ? (((ua >> (16 - ub)) & 1) != 0) : 1'b0;
      end
      5'd14: begin
        ry = (ub >= 16) ? 16'h0 : 16'(ua >> ub);
        fl[3] = (ub >= 1 && ub <= 16) ? (((ua >> (ub - 1)) & 1) != 0) : 1'b0;
      end
      5'd15: begin
        ry = (ub >= 16) ? ((sa < 0) ? 16'hFFFF : 16'h0) : 16'(sa >>> ub);
        if (ub == 0) fl[3] = 1'b0;
        else if (ub <= 16) fl[3] = (((sa >>> (ub - 1)) & 1) != 0);
        else fl[3] = (sa < 0);
      end
      5'd16: return prev;
      5'd17: begin
        std = 1'b0;
        fl[5] = (ua == ub);
        fl[1] = (ua > ub);
        fl[0] = (ua < ub);
        fl[2] = (($countones(16'(ua - ub)) % 2) == 0);
      end
`ifdef ALU_SIGNED_DIV_EN
      5'd18: begin
        if (ub == 0) begin ry = 16'hFFFF; fl[4] = 1'b1; end
        else if (x == 16'h8000 && z == 16'hFFFF) begin ry = 16'h8000; fl[4] = 1'b1; end
        else ry = 16'(sa / sz);
      end
      5'd19: begin
        if (ub == 0) begin ry = x; fl[4] = 1'b1; end
        else ry = 16'(sa % sz);
      end
`endif
      default: std = 1'b0;
    endcase
    if (std) begin
      fl[5] = (ry == 0);
      fl[2] = (($countones(ry) % 2) == 0);
    end
    return {ry, fl};
  endfunction

  // Model side of the handshake: decide acceptance and schedule the result.
  always @(posedge clk) begin
    m_acc = rst_n && start && (ecount >= busy_end);
    ecount++;
    if (m_acc) begin
      m_res = model(func, a, b, flags_in[3], m_prev);
      m_prev = m_res;
      exp_q.push_back(m_res[21:6]);
      exp_flags_q.push_back(m_res[5:0]);
      if (is_div_op(func)) begin
        exp_due_q.push_back(ecount + DIV_LAT);
        busy_end = ecount + DIV_LAT;
      end else begin
        exp_due_q.push_back(ecount + 1);
      end
    end
  end

  // scoreboard compare, every cycle out of reset
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", ready, (ecount >= busy_end));
      if (exp_due_q.size() > 0 && exp_due_q[0] == ecount) begin
        check("done", done, 1);
        check("y", y, exp_q[0]);
        check("flags", flags_out, exp_flags_q[0]);
        void'(exp_due_q.pop_front());
        void'(exp_q.pop_front());
        void'(exp_flags_q.pop_front());
      end else begin
        check("done_idle", done, 0);
      end
    end
  end

  // driver tasks: called at a falling edge, return at the next one
  task automatic drive(input logic s, input logic [4:0] f, input logic [W-1:0] x,
                       input logic [W-1:0] z, input logic c);
    start    = s;
    func     = f;
    a        = x;
    b        = z;
    flags_in = 6'($urandom_range(0, 63));
    flags_in[3] = c;
    @(negedge clk);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 40 && ecount < busy_end; k++) drive(1'b0, 5'd0, '0, '0, 1'b0);
    check("wait_ready_timeout", (ecount >= busy_end), 1);
  endtask

  task automatic directed(input string name, input logic [4:0] f, input logic [W-1:0] x,
                          input logic [W-1:0] z, input logic c,
                          input logic [W-1:0] lit_y, input logic [5:0] lit_f);
    wait_ready();
    check(name, model(f, x, z, c, m_prev), {lit_y, lit_f});
    drive(1'b1, f, x, z, c);
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_flags"}, flags_out, 0);
  endtask

  initial begin
    logic [4:0]   f;
    logic [W-1:0] x, z;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    func = '0;
    flags_in = '0;
    repeat (2) @(negedge clk);
    reset_check("por");
    #2 rst_n = 1'b1;
    @(negedge clk);

    directed("pin_add_carry", 5'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 6'h34);
    directed("pin_div", 5'd3, 16'd100, 16'd7, 1'b0, 16'd14, 6'h00);
    directed("pin_mod", 5'd4, 16'd100, 16'd7, 1'b0, 16'd2, 6'h00);
    directed("pin_div0", 5'd3, 16'd5, 16'd0, 1'b0, 16'hFFFF, 6'h14);
    directed("pin_asr4", 5'd15, 16'h8000, 16'd4, 1'b0, 16'hF800, 6'h00);
    directed("pin_asr20", 5'd15, 16'h8000, 16'd20, 1'b0, 16'hFFFF, 6'h0C);
    directed("pin_lsl1", 5'd13, 16'h8001, 16'd1, 1'b0, 16'h0002, 6'h08);
    directed("pin_cmp", 5'd17, 16'd3, 16'd5, 1'b0, 16'h0000, 6'h01);
    directed("pin_sub_borrow", 5'd1, 16'd3, 16'd5, 1'b1, 16'hFFFD, 6'h10);

    // ADD issued mid-divide must be dropped
    wait_ready();
    drive(1'b1, 5'd3, 16'd100, 16'd7, 1'b0);
    repeat (3) drive(1'b0, 5'd0, '0, '0, 1'b0);
    drive(1'b1, 5'd0, 16'd1, 16'd1, 1'b0);
    drive(1'b0, 5'd0, '0, '0, 1'b0);

    // asynchronous reset in the middle of a divide
    wait_ready();
    drive(1'b1, 5'd3, 16'd1234, 16'd5, 1'b0);
    repeat (7) drive(1'b0, 5'd0, '0, '0, 1'b0);
    #3 rst_n = 1'b0;
    #1 reset_check("mid_div_rst");
    exp_q.delete();
    exp_flags_q.delete();
    exp_due_q.delete();
    m_prev = '0;
    busy_end = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    directed("pin_add_after_rst", 5'd0, 16'd2, 16'd3, 1'b1, 16'd6, 6'h04);

    // random traffic, including ignored starts while a divide runs
    for (int i = 0; i < 400; i++) begin
      f = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
      x = 16'($urandom);
      z = 16'($urandom);
      if (f inside {5'd13, 5'd14, 5'd15} && $urandom_range(0, 1) == 1) z = 16'($urandom_range(0, 20));
      if (f inside {5'd3, 5'd4, 5'd18, 5'd19} && $urandom_range(0, 3) == 0) z = '0;
      if (f inside {5'd3, 5'd4} && $urandom_range(0, 2) == 0) z = 16'($urandom_range(1, 300));
      drive(1'($urandom_range(0, 3) != 0), f, x, z, 1'($urandom_range(0, 1)));
    end

    start = 1'b0;
    for (int k = 0; k < 64 && exp_due_q.size() > 0; k++) @(negedge clk);
    check("drain", exp_due_q.size(), 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
